// File: rtl/demux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// demux_rr_scheduler
//
// Purpose
//   Takes one word at a time from a single source and hands it to one of
//   eight destinations. The destination is picked by round robin over the
//   destinations that are ready. A word is granted when it is accepted, and
//   it is then held (Data_Out / Select_Out) until that destination takes it.
//   Data_Out is shared by all eight destinations. Select_Out drives an
//   external 1:8 demux select.
//
// Handshake semantics
//   Source side: a word moves when Data_Valid_In & Data_Ready_Out in the
//   same cycle. Data_Ready_Out depends combinationally on Enable_In and
//   Dest_Ready_In, so the source must not make Data_Valid_In depend on
//   Data_Ready_Out.
//   Destination side: a word moves when Dest_Valid_Out[n] & Dest_Ready_In[n]
//   in the same cycle. Once Dest_Valid_Out[n] is raised it stays raised, with
//   Data_Out and Select_Out unchanged, until destination n takes the word.
//   There is no re-arbitration while a word is held.
//
// Ports
//   Clock_In            rising-edge clock
//   Reset_In            asynchronous, active-low reset
//   Enable_In           allows new words to be accepted (held words still drain)
//   Data_In             source payload
//   Data_Valid_In       source has a word on Data_In
//   Data_Ready_Out      block accepts the source word this cycle
//   Dest_Ready_In[7:0]  destination n can take a word
//   Dest_Valid_Out[7:0] one-hot (or zero): word offered to destination n
//   Data_Out            held payload
//   Select_Out[2:0]     index of the granted destination
//   Transfer_Count_Out  completed destination transfers (wraps at 16 bits)
//   State_Out           debug: 0 = IDLE, 1 = SEND
// -----------------------------------------------------------------------------
module demux_rr_scheduler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  input  logic [7:0]            Dest_Ready_In,
  output logic [7:0]            Dest_Valid_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic [2:0]            Select_Out,
  output logic [15:0]           Transfer_Count_Out,
  output logic                  State_Out
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2:0]              last_grant;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2:0]              select_q;
  logic [15:0]             count_q;

  logic                    complete;
  logic                    accept;
  logic                    data_ready;
  logic                    any_dest_ready;
  logic [2:0]              search_start;
  logic [2:0]              grant;

  // ---------------------------------------------------------------------------
  // Handshake terms
  // ---------------------------------------------------------------------------
  assign any_dest_ready = |Dest_Ready_In;
  assign complete       = (state == SEND) & Dest_Ready_In[select_q];

  // A new word is accepted from IDLE, or in the same cycle the held word
  // leaves. This gives one word per cycle while destinations keep up.
  assign data_ready = Enable_In & any_dest_ready & ((state == IDLE) | complete);
  assign accept     = Data_Valid_In & data_ready;

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // If the held word leaves this cycle, last_grant is only updated at the
  // clock edge, so the search starts from the outgoing select instead. When
  // that destination is the only one ready, the search wraps back to it.
  // ---------------------------------------------------------------------------
  assign search_start = (complete ? select_q : last_grant) + 3'd1;

  always_comb begin
    logic [2:0] idx;
    logic       found;
    grant = search_start;
    found = 1'b0;
    idx   = search_start;
    for (int i = 0; i < 8; i++) begin
      idx = search_start + 3'(i);
      if (!found && Dest_Ready_In[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          state_next = SEND;
        end else if (complete) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      data_q   <= '0;
      select_q <= 3'd0;
    end else if (accept) begin
      data_q   <= Data_In;
      select_q <= grant;
    end
  end

  // Reset value 7 makes the first search after reset start at destination 0.
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      last_grant <= 3'd7;
    end else if (complete) begin
      last_grant <= select_q;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      count_q <= 16'd0;
    end else if (complete) begin
      count_q <= count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // Dest_Valid_Out is decoded from registered state only, so it drops to zero
  // as soon as reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    Dest_Valid_Out = 8'd0;
    if (state == SEND) begin
      Dest_Valid_Out[select_q] = 1'b1;
    end
  end

  assign Data_Ready_Out     = data_ready;
  assign Data_Out           = data_q;
  assign Select_Out         = select_q;
  assign Transfer_Count_Out = count_q;
  assign State_Out          = state;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_demux_rr_scheduler
//
// Bench for demux_rr_scheduler. A driver applies one input set per cycle
// and runs a transaction-level reference model. On every accepted word the
// model pushes the expected {grant, data} into exp_q. A separate monitor
// pops and compares whenever a destination transfer happens.
// -----------------------------------------------------------------------------
module tb_demux_rr_scheduler;

  localparam int DW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          Clock_In = 1'b0;
  logic          Reset_In;
  logic          Enable_In;
  logic [DW-1:0] Data_In;
  logic          Data_Valid_In;
  logic          Data_Ready_Out;
  logic [7:0]    Dest_Ready_In;
  logic [7:0]    Dest_Valid_Out;
  logic [DW-1:0] Data_Out;
  logic [2:0]    Select_Out;
  logic [15:0]   Transfer_Count_Out;
  logic          State_Out;

  always #5 Clock_In = ~Clock_In;

  demux_rr_scheduler #(.DATA_WIDTH(DW)) dut (
    .Clock_In           (Clock_In),
    .Reset_In           (Reset_In),
    .Enable_In          (Enable_In),
    .Data_In            (Data_In),
    .Data_Valid_In      (Data_Valid_In),
    .Data_Ready_Out     (Data_Ready_Out),
    .Dest_Ready_In      (Dest_Ready_In),
    .Dest_Valid_Out     (Dest_Valid_Out),
    .Data_Out           (Data_Out),
    .Select_Out         (Select_Out),
    .Transfer_Count_Out (Transfer_Count_Out),
    .State_Out          (State_Out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  logic [DW+2:0] exp_q[$];

  logic          m_held;
  logic [2:0]    m_sel;
  logic [2:0]    m_last;
  logic [DW-1:0] m_data;
  logic [15:0]   m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_held  = 1'b0;
    m_sel   = 3'd0;
    m_last  = 3'd7;
    m_data  = '0;
    m_count = 16'd0;
    exp_q.delete();
  endtask

  // First ready destination searching upward (with wrap) from start.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    for (int n = 0; n < 8; n++) begin
      if (r[(int'(start) + n) % 8]) return 3'((int'(start) + n) % 8);
    end
    return start;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one cycle of stimulus, then model check/update at the falling edge
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic en, input logic v, input logic [DW-1:0] d,
                       input logic [7:0] r);
    logic       complete;
    logic       exp_ready;
    logic [2:0] start;
    logic [2:0] g;
    logic [7:0] oh;
    @(posedge Clock_In);
    #1;
    Enable_In     = en;
    Data_Valid_In = v;
    Data_In       = d;
    Dest_Ready_In = r;
    @(negedge Clock_In);
    oh = m_held ? (8'h01 << m_sel) : 8'h00;
    check("dest_valid", Dest_Valid_Out, oh);
    check("state", State_Out, m_held);
    check("count", Transfer_Count_Out, m_count);
    if (m_held) begin
      check("held_data", Data_Out, m_data);
      check("held_select", Select_Out, m_sel);
    end
    complete  = m_held && r[m_sel];
    exp_ready = en && (r != 8'h00) && (!m_held || complete);
    check("data_ready", Data_Ready_Out, exp_ready);
    start = complete ? (m_sel + 3'd1) : (m_last + 3'd1);
    if (complete) begin
      m_last  = m_sel;
      m_count = m_count + 16'd1;
    end
    if (v && exp_ready) begin
      g = rr_pick(r, start);
      exp_q.push_back({g, d});
      m_held = 1'b1;
      m_sel  = g;
      m_data = d;
    end else if (complete) begin
      m_held = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops on every observed destination transfer
  // ---------------------------------------------------------------------------
  always @(negedge Clock_In) begin
    logic [DW+2:0] e;
    if (Reset_In === 1'b1 && (Dest_Valid_Out & Dest_Ready_In) != 8'h00) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: actual select=%0d data=%0h required=no transfer at %0t",
                 Select_Out, Data_Out, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_select", Select_Out, e[DW+2:DW]);
        check("sb_data", Data_Out, e[DW-1:0]);
      end
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished at %0t", $time);
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset_In      = 1'b0;
    Enable_In     = 1'b0;
    Data_Valid_In = 1'b0;
    Data_In       = '0;
    Dest_Ready_In = 8'h00;
    model_reset();
    repeat (3) @(posedge Clock_In);
    @(negedge Clock_In);
    check("rst_dest_valid", Dest_Valid_Out, 8'h00);
    check("rst_data_out", Data_Out, 0);
    check("rst_select", Select_Out, 0);
    check("rst_count", Transfer_Count_Out, 0);
    check("rst_state", State_Out, 0);
    @(posedge Clock_In);
    #1;
    Reset_In = 1'b1;

    // Single transfer.
    cycle(1'b1, 1'b1, 8'hA5, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    check("single_count", Transfer_Count_Out, 1);

    // Round-robin streaming, ten back-to-back words.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'($urandom), 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);

    // Sparse ready mask.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'($urandom), 8'b0010_0100);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);

    // Destination stall on 3 for five cycles.
    cycle(1'b1, 1'b1, 8'h3C, 8'h08);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'($urandom), 8'hF7);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);

    // Enable and no-destination gating; enable falls while a word is held.
    cycle(1'b0, 1'b1, 8'h11, 8'hFF);
    cycle(1'b0, 1'b1, 8'h22, 8'hFF);
    cycle(1'b1, 1'b1, 8'h33, 8'h00);
    cycle(1'b1, 1'b1, 8'h44, 8'h00);
    cycle(1'b1, 1'b1, 8'h55, 8'hFF);
    cycle(1'b0, 1'b1, 8'h66, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00, 8'hFF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), 1'($urandom),
            8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);

    // Reset while a word is held.
    cycle(1'b1, 1'b1, 8'h5A, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    #2;
    Reset_In = 1'b0;
    #1;
    check("mid_rst_dest_valid", Dest_Valid_Out, 8'h00);
    check("mid_rst_data_out", Data_Out, 0);
    check("mid_rst_select", Select_Out, 0);
    check("mid_rst_count", Transfer_Count_Out, 0);
    check("mid_rst_state", State_Out, 0);
    model_reset();
    Data_Valid_In = 1'b0;
    Dest_Ready_In = 8'hFF;
    @(posedge Clock_In);
    #1;
    Reset_In = 1'b1;
    cycle(1'b1, 1'b1, 8'hC3, 8'hFF);
    check("post_rst_grant", m_sel, 0);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    check("post_rst_count", Transfer_Count_Out, 1);

    // Counter wrap: bring the count to FFFF, then one more transfer.
    for (int i = 0; i < 65534; i++) cycle(1'b1, 1'b1, 8'($urandom), 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    check("count_ffff", Transfer_Count_Out, 16'hFFFF);
    cycle(1'b1, 1'b1, 8'h99, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF);
    check("count_wrap", Transfer_Count_Out, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
DEMUX_RR_SCHEDULER -- requirements
Module: DEMUX_RR_SCHEDULER

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port Clock_In, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port Reset_In, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port Enable_In, input, 1: when high, new words may be accepted.
REQ-005 The block SHALL have port Data_In, input, DATA_WIDTH: the source payload.
REQ-006 The block SHALL have port Data_Valid_In, input, 1: the source has a word on Data_In.
REQ-007 The block SHALL have port Data_Ready_Out, output, 1: the block accepts the source word this cycle.
REQ-008 The block SHALL have port Dest_Ready_In, input, 8: bit n high means destination n can take a word.
REQ-009 The block SHALL have port Dest_Valid_Out, output, 8: one-hot or zero; bit n means the word is offered to destination n.
REQ-010 The block SHALL have port Data_Out, output, DATA_WIDTH: the held payload, shared by all destinations.
REQ-011 The block SHALL have port Select_Out, output, 3: the index of the granted destination, used to drive the 1:8 demux select.
REQ-012 The block SHALL have port Transfer_Count_Out, output, 16: the number of completed destination transfers.

Function
REQ-013 The FSM SHALL have two states: IDLE (nothing held) and SEND (one word held).
REQ-014 The block SHALL define accept as Data_Valid_In & Data_Ready_Out.
REQ-015 The block SHALL define complete as SEND & Dest_Ready_In[Select_Out].
REQ-016 Data_Ready_Out SHALL be combinational and equal Enable_In & (Dest_Ready_In != 0) & (IDLE | complete).
REQ-017 On accept, the block SHALL register Data_In into Data_Out and the grant index into Select_Out, and enter or stay in SEND.
REQ-018 Round-robin grant: the grant SHALL be the first set bit of Dest_Ready_In, searching upward with wrap from (Last_Grant+1) mod 8.
- Last_Grant is a 3-bit register.
REQ-019 On complete, Last_Grant SHALL take the value of Select_Out.
- On a simultaneous complete and accept, the search SHALL start at Select_Out+1.
- That grant MAY equal the current Select_Out when it is the only ready destination.
REQ-020 On complete without accept, the state SHALL return to IDLE.
REQ-021 In SEND, Dest_Valid_Out SHALL be the one-hot decode of Select_Out; in IDLE it SHALL be 0.
REQ-022 Data_Out and Select_Out SHALL be stable while in SEND until complete.
REQ-023 A deasserted Dest_Ready_In[Select_Out] in SEND SHALL hold the word with no re-arbitration.
REQ-024 Enable_In low SHALL block new accepts only; a held word SHALL still complete.
REQ-025 Transfer_Count_Out SHALL increment by 1 on each complete and wrap from 16'hFFFF to 0.
REQ-026 Throughput SHALL be one word per cycle when granted destinations are ready.
REQ-027 Latency from accept to Dest_Valid_Out SHALL be 1 cycle.

Reset
REQ-028 While Reset_In is low, the block SHALL immediately force the following:
- state IDLE
- Last_Grant = 3'd7
- Data_Out = 0
- Select_Out = 0
- Dest_Valid_Out = 0
- Transfer_Count_Out = 0
REQ-029 A reset asserted during SEND SHALL discard the held word without completing it.
REQ-030 After reset, the first grant SHALL search from destination 0.

Verification
REQ-031 The bench SHALL cover single transfer: reset release; Enable_In=1, Dest_Ready_In=8'hFF, one word 8'hA5.
- Required response: next cycle Dest_Valid_Out=8'h01, Select_Out=0, Data_Out=8'hA5.
- Required response: count=1 after complete.
REQ-032 The bench SHALL cover round-robin streaming: Dest_Ready_In=8'hFF, 10 back-to-back words.
- Required response: Select_Out sequence 0,1,...,7,0,1.
- Required response: Data_Ready_Out high every cycle; count=10.
REQ-033 The bench SHALL cover a sparse ready mask: Dest_Ready_In=8'b0010_0100, 4 words.
- Required response: grants 2,5,2,5.
REQ-034 The bench SHALL cover a destination stall: Dest_Ready_In[3] drops while Select_Out=3, for 5 cycles.
- Required response: Dest_Valid_Out=8'h08 and Data_Out stay held; Data_Ready_Out=0; no count change until [3] returns.
REQ-035 The bench SHALL cover enable and no-destination gating:
- Enable_In=0 with Data_Valid_In=1: Data_Ready_Out=0.
- Dest_Ready_In=0 in IDLE: Data_Ready_Out=0.
- Required response: the held word completes when Enable_In falls during SEND.
REQ-036 The bench SHALL cover mid-operation reset and count wrap:
- Reset in SEND: all outputs reach their reset values immediately; the next grant is 0.
- Counter preloaded near 16'hFFFF by 65535 transfers: the next complete gives 0.
